// File: rtl/vga_pixel_fetch.sv
// VGA raster timing plus frame-buffer read engine; each stored pixel is replicated SCALE x SCALE.
// Outputs lag the raster counters by 2 HCLK (address register, then RAM read). The raster free-runs with no backpressure.
module vga_pixel_fetch #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned SCALE      = 4,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FB_W    = H_ACTIVE / SCALE;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0]         H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]         H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]         HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]         HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]         V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]         V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]         VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]         VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DW-1:0]         DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [SW-1:0]         S_LAST   = SW'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_W);

  logic [DW-1:0]         div_q, div_d;
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [SW-1:0]         x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [ADDR_WIDTH-1:0] x_fb_q, x_fb_d, row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic de_p1_q, hs_p1_q, vs_p1_q, fs_p1_q;
  logic de_q, hs_q, vs_q, fs_q;
  logic [DATA_WIDTH-1:0] rgb_q;

  logic tick, de_raw, hs_raw, vs_raw, fs_raw;

  assign tick   = (div_q == DIV_LAST);
  assign de_raw = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
  assign vs_raw = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
  assign fs_raw = (h_q == '0) && (v_q == '0) && (div_q == '0);

  // Address is built incrementally (x_fb, row_base) so no multiplier is needed.
  always_comb begin
    div_d      = div_q;
    h_d        = h_q;
    v_d        = v_q;
    x_sub_d    = x_sub_q;
    x_fb_d     = x_fb_q;
    y_sub_d    = y_sub_q;
    row_base_d = row_base_q;
    rd_addr_d  = rd_addr_q;
    if (tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d     = '0;
        x_sub_d = '0;
        x_fb_d  = '0;
        if (v_q == V_LAST) begin
          v_d        = '0;
          y_sub_d    = '0;
          row_base_d = '0;
        end else begin
          v_d = v_q + 1'b1;
          if (v_q < V_ACT) begin
            if (y_sub_q == S_LAST) begin
              y_sub_d    = '0;
              row_base_d = row_base_q + ROW_STEP;
            end else begin
              y_sub_d = y_sub_q + 1'b1;
            end
          end
        end
      end else begin
        h_d = h_q + 1'b1;
        if (h_q < H_ACT) begin
          if (x_sub_q == S_LAST) begin
            x_sub_d = '0;
            x_fb_d  = x_fb_q + 1'b1;
          end else begin
            x_sub_d = x_sub_q + 1'b1;
          end
        end
      end
      rd_addr_d = ((h_d < H_ACT) && (v_d < V_ACT)) ? (row_base_d + x_fb_d) : '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      x_sub_q    <= '0;
      x_fb_q     <= '0;
      y_sub_q    <= '0;
      row_base_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      x_sub_q    <= x_sub_d;
      x_fb_q     <= x_fb_d;
      y_sub_q    <= y_sub_d;
      row_base_q <= row_base_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Stage 1 waits out the RAM read; stage 2 merges rd_data and applies enable.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      de_p1_q <= 1'b0;
      hs_p1_q <= 1'b1;
      vs_p1_q <= 1'b1;
      fs_p1_q <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      de_p1_q <= de_raw;
      hs_p1_q <= hs_raw;
      vs_p1_q <= vs_raw;
      fs_p1_q <= fs_raw;
      de_q    <= de_p1_q & enable;
      hs_q    <= hs_p1_q;
      vs_q    <= vs_p1_q;
      fs_q    <= fs_p1_q;
      rgb_q   <= (de_p1_q & enable) ? rd_data : '0;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a small raster (14x7 totals, SCALE 2, PIX_DIV 2); the RAM model returns word = address.
module tb_vga_pixel_fetch;

  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int PD = 2, SC = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FBW = HA / SC;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        enable = 1'b1;
  logic [14:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  rgb;

  vga_pixel_fetch #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .PIX_DIV(PD), .SCALE(SC), .ADDR_WIDTH(15), .DATA_WIDTH(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .enable(enable),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) rd_data <= rd_addr[7:0];

  typedef struct packed {
    logic [14:0] addr;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [7:0]  rgb;
  } exp_t;

  typedef struct {
    int   n;
    logic en;
    exp_t e;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   n = 0;
  vec_t tbl[$];

  function automatic vec_t mk(int nn, int a, bit d, bit h, bit v, bit f, int r);
    vec_t t;
    t.n = nn;
    t.en = 1'b1;
    t.e = '{addr: 15'(a), de: d, hs: h, vs: v, fs: f, rgb: 8'(r)};
    return t;
  endfunction

  function automatic int fb_addr(int h, int v);
    return (h < HA && v < VA) ? (v / SC) * FBW + h / SC : 0;
  endfunction

  // Expected state n edges after reset release; en is enable as seen at edge n.
  function automatic exp_t model(int nn, bit en);
    exp_t e;
    int p, h, v, m;
    p = nn / PD;
    h = p % HT;
    v = (p / HT) % VT;
    e.addr = 15'(fb_addr(h, v));
    e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.rgb = 8'd0;
    if (nn >= 2) begin
      m = nn - 2;
      p = m / PD;
      h = p % HT;
      v = (p / HT) % VT;
      e.de  = (h < HA) && (v < VA) && en;
      e.rgb = e.de ? 8'(fb_addr(h, v)) : 8'd0;
      e.hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
      e.vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
      e.fs  = (h == 0) && (v == 0) && (m % PD == 0);
    end
    return e;
  endfunction

  task automatic check(string name, exp_t w);
    exp_t a;
    a = '{addr: rd_addr, de: de, hs: hsync, vs: vsync, fs: frame_start, rgb: rgb};
    tests++;
    if (a !== w) begin
      fails++;
      $display("FAIL %s n=%0d got addr=%0d de=%0b hs=%0b vs=%0b fs=%0b rgb=%0d want addr=%0d de=%0b hs=%0b vs=%0b fs=%0b rgb=%0d",
               name, n, a.addr, a.de, a.hs, a.vs, a.fs, a.rgb, w.addr, w.de, w.hs, w.vs, w.fs, w.rgb);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    n++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog n=%0d got timeout want finish", n);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    bit   found;
    rst_e = '{addr: 15'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 8'd0};

    // Table: line 0 fetch pattern, blanking, sync pulses, second frame start.
    tbl.push_back(mk(0,   0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1,   0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(2,   0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(3,   0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4,   1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(6,   1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(8,   2, 1, 1, 1, 0, 1));
    tbl.push_back(mk(10,  2, 1, 1, 1, 0, 2));
    tbl.push_back(mk(14,  3, 1, 1, 1, 0, 3));
    tbl.push_back(mk(16,  0, 1, 1, 1, 0, 3));
    tbl.push_back(mk(17,  0, 1, 1, 1, 0, 3));
    tbl.push_back(mk(18,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(21,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(22,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(25,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(26,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(28,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(30,  0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(34,  1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(49,  0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(50,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(56,  4, 0, 1, 1, 0, 0));
    tbl.push_back(mk(58,  4, 1, 1, 1, 0, 4));
    tbl.push_back(mk(62,  5, 1, 1, 1, 0, 5));
    tbl.push_back(mk(96,  7, 1, 1, 1, 0, 6));
    tbl.push_back(mk(112, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(114, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(141, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(142, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(169, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(170, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(197, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(198, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(199, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(200, 1, 1, 1, 1, 0, 0));

    HRESETn = 1'b0;
    enable  = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_values", rst_e);

    @(negedge HCLK);
    HRESETn = 1'b1;
    n = 0;
    #1;
    foreach (tbl[i]) begin
      while (n < tbl[i].n) begin
        enable = tbl[i].en;
        step();
      end
      check($sformatf("table_%0d", tbl[i].n), tbl[i].e);
    end

    while (n < 262) begin
      enable = 1'b1;
      step();
      check("run_to_line2", model(n, 1'b1));
    end

    // Blank mid line 2, then re-enable at pixel h=5 (x_fb 2, address 6).
    enable = 1'b0;
    step();
    check("enable_off", '{addr: 15'd6, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 8'd0});
    enable = 1'b1;
    step();
    check("enable_on", '{addr: 15'd7, de: 1'b1, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 8'd6});

    for (int k = 0; k < 500; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      step();
      check("random_enable", model(n, enable));
    end

    found = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      check("seek_h5_v2", model(n, 1'b1));
      found = ((n / PD) % HT == 5) && (((n / PD) / HT) % VT == 2);
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL seek_h5_v2 got not_reached want h=5 v=2");
    end

    #2;
    HRESETn = 1'b0;
    #1;
    check("async_reset", rst_e);
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_held", rst_e);

    @(negedge HCLK);
    HRESETn = 1'b1;
    n = 0;
    #1;
    check("restart_0", model(0, 1'b1));
    for (int k = 0; k < 120; k++) begin
      enable = 1'b1;
      step();
      check("restart", model(n, 1'b1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
